id_ex_pipe_reg: RTL

//  ID/EX pipeline register for the 5-stage RV32I core, directly downstream of the combined

---
 rtl/id_ex_pipe_reg.sv | 108 ++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use hazard stall, branch flush and bubble counter
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [2:0]       OperationD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             PCSrcE,

    output logic             RegWriteE,
    output logic [1:0]       ResultSrcE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [2:0]       OperationE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,

    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic [CNT_W-1:0] BubbleCount
);

    logic lw_stall;
    logic flush_e;

    // Rs2D is compared even when the instruction does not read rs2; the occasional
    // spurious stall is cheaper than decoding operand usage here.
    assign lw_stall = (ResultSrcE == 2'b01) & (RdE != 5'd0) &
                      ((Rs1D == RdE) | (Rs2D == RdE));

    // A taken branch overrides the load-use stall: the D instruction is wrong-path anyway.
    assign StallF  = lw_stall & ~PCSrcE;
    assign StallD  = lw_stall & ~PCSrcE;
    assign FlushD  = PCSrcE;
    assign flush_e = lw_stall | PCSrcE;

    // A bubble clears data and indices too, so RdE=0 never matches a hazard or forward compare.
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            RegWriteE  <= 1'b0;
            ResultSrcE <= 2'b00;
            MemWriteE  <= 1'b0;
            JumpE      <= 1'b0;
            BranchE    <= 1'b0;
            ALUSrcE    <= 1'b0;
            OperationE <= 3'b000;
            RD1E       <= '0;
            RD2E       <= '0;
            PCE        <= '0;
            PCPlus4E   <= '0;
            ImmExtE    <= '0;
            Rs1E       <= 5'd0;
            Rs2E       <= 5'd0;
            RdE        <= 5'd0;
        end else begin
            RegWriteE  <= RegWriteD;
            ResultSrcE <= ResultSrcD;
            MemWriteE  <= MemWriteD;
            JumpE      <= JumpD;
            BranchE    <= BranchD;
            ALUSrcE    <= ALUSrcD;
            OperationE <= OperationD;
            RD1E       <= RD1D;
            RD2E       <= RD2D;
            PCE        <= PCD;
            PCPlus4E   <= PCPlus4D;
            ImmExtE    <= ImmExtD;
            Rs1E       <= Rs1D;
            Rs2E       <= Rs2D;
            RdE        <= RdD;
        end
    end

    // Saturating so long flush storms stay readable instead of wrapping to small values.
    always_ff @(posedge clk) begin
        if (rst) begin
            BubbleCount <= '0;
        end else if (flush_e && (BubbleCount != {CNT_W{1'b1}})) begin
            BubbleCount <= BubbleCount + CNT_W'(1);
        end
    end

endmodule
